ld_alloc_ctrl: RTL

LD_ALLOC_CTRL -- requirements
Module: ld_alloc_ctrl

---
 rtl/slv_pkg.sv | 20 ++
 rtl/lzc.sv | 27 ++
 rtl/ld_alloc_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/slv_pkg.sv
// Shared types for the slave-side LD table: ID/index widths and per-ID
// FIFO bookkeeping used by ld_alloc_ctrl.
package slv_pkg;

   localparam int unsigned AxiIntIdWidth = 5;
   localparam int unsigned LdIdxWidth    = 5;
   // Per-ID count can never exceed the largest table the index width can address.
   localparam int unsigned LdCntWidth    = $clog2((2 ** LdIdxWidth) + 1);

   typedef logic [AxiIntIdWidth-1:0] int_id_t;
   typedef logic [LdIdxWidth-1:0]    ld_idx_t;
   typedef logic [LdCntWidth-1:0]    ld_cnt_t;

   typedef struct packed {
      ld_idx_t head;
      ld_idx_t tail;
      ld_cnt_t cnt;
   } ld_id_state_t;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter: MODE=0 gives the index of the lowest set bit,
// MODE=1 the number of zeros above the highest set bit.
module lzc #(
   parameter int unsigned WIDTH     = 2,
   parameter bit          MODE      = 1'b0,
   parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0]     in_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 empty_o
);

   always_comb begin
      cnt_o   = '0;
      empty_o = ~|in_i;
      if (MODE) begin
         for (int unsigned k = 0; k < WIDTH; k++) begin
            if (in_i[k]) cnt_o = CNT_WIDTH'(WIDTH - 1 - k);
         end
      end else begin
         for (int unsigned k = 0; k < WIDTH; k++) begin
            if (in_i[WIDTH-1-k]) cnt_o = CNT_WIDTH'(WIDTH - 1 - k);
         end
      end
   end

endmodule

// File: rtl/ld_alloc_ctrl.sv
// LD table allocator: hands out free entries and keeps a linked FIFO of
// outstanding entries per internal ID so responses retire in order.
module ld_alloc_ctrl
   import slv_pkg::*;
#(
   parameter int unsigned MaxUniqIds   = 32,
   parameter int unsigned MaxTxnsPerId = 1,
   parameter int unsigned MaxTxns      = MaxUniqIds * MaxTxnsPerId
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          enq_req_i,
   input  logic [AxiIntIdWidth-1:0]      enq_id_i,
   output logic                          enq_gnt_o,
   output logic [LdIdxWidth-1:0]         enq_idx_o,
   input  logic                          deq_req_i,
   input  logic [AxiIntIdWidth-1:0]      deq_id_i,
   output logic                          deq_hit_o,
   output logic [LdIdxWidth-1:0]         deq_idx_o,
   output logic                          deq_err_o,
   output logic [MaxTxns-1:0]            entry_busy_o,
   output logic [MaxTxns*LdIdxWidth-1:0] next_idx_o,
   output logic                          full_o,
   output logic                          empty_o
);

   localparam int unsigned IdSelW  = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1;
   localparam int unsigned IdxSelW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;

   ld_id_state_t       id_q   [MaxUniqIds];
   ld_id_state_t       id_d   [MaxUniqIds];
   ld_idx_t            next_q [MaxTxns];
   ld_idx_t            next_d [MaxTxns];
   logic [MaxTxns-1:0] busy_q, busy_d;
   logic               deq_err_q, deq_err_d;

   logic [IdxSelW-1:0] free_sel;
   logic               no_free;
   ld_idx_t            free_idx;
   logic [IdSelW-1:0]  enq_sel, deq_sel;
   logic [IdxSelW-1:0] head_sel;
   logic               enq_id_ok, deq_id_ok, deq_fire;

   lzc #(
      .WIDTH     (MaxTxns),
      .MODE      (1'b0),
      .CNT_WIDTH (IdxSelW)
   ) i_first_free (
      .in_i    (~busy_q),
      .cnt_o   (free_sel),
      .empty_o (no_free)
   );

   assign free_idx  = ld_idx_t'(free_sel);
   assign enq_sel   = enq_id_i[IdSelW-1:0];
   assign deq_sel   = deq_id_i[IdSelW-1:0];
   assign enq_id_ok = 32'(enq_id_i) < MaxUniqIds;
   assign deq_id_ok = 32'(deq_id_i) < MaxUniqIds;
   assign head_sel  = id_q[deq_sel].head[IdxSelW-1:0];

   assign full_o       = no_free;
   assign empty_o      = ~|busy_q;
   assign entry_busy_o = busy_q;
   assign enq_idx_o    = free_idx;
   assign deq_err_o    = deq_err_q;

   assign enq_gnt_o = enq_req_i & ~rst_i & ~full_o & enq_id_ok &
                      (id_q[enq_sel].cnt < ld_cnt_t'(MaxTxnsPerId));
   assign deq_hit_o = deq_id_ok & (id_q[deq_sel].cnt != '0);
   assign deq_idx_o = id_q[deq_sel].head;
   assign deq_fire  = deq_req_i & deq_hit_o;

   always_comb begin
      next_idx_o = '0;
      for (int unsigned i = 0; i < MaxTxns; i++) begin
         next_idx_o[i*LdIdxWidth +: LdIdxWidth] = next_q[i];
      end
   end

   // Retire is applied before allocate so a same-ID enq+deq sees the
   // post-retire count and links onto the surviving tail (or becomes head).
   always_comb begin
      busy_d    = busy_q;
      next_d    = next_q;
      id_d      = id_q;
      deq_err_d = deq_req_i & ~deq_hit_o;

      if (deq_fire) begin
         busy_d[head_sel]   = 1'b0;
         id_d[deq_sel].cnt  = id_q[deq_sel].cnt - ld_cnt_t'(1);
         if (id_q[deq_sel].cnt > ld_cnt_t'(1)) begin
            id_d[deq_sel].head = next_q[head_sel];
         end
      end

      if (enq_gnt_o) begin
         busy_d[free_sel] = 1'b1;
         next_d[free_sel] = free_idx;
         if (id_d[enq_sel].cnt == '0) begin
            id_d[enq_sel].head = free_idx;
         end else begin
            next_d[id_d[enq_sel].tail[IdxSelW-1:0]] = free_idx;
         end
         id_d[enq_sel].tail = free_idx;
         id_d[enq_sel].cnt  = id_d[enq_sel].cnt + ld_cnt_t'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q    <= '0;
         deq_err_q <= 1'b0;
         id_q      <= '{default: '0};
         next_q    <= '{default: '0};
      end else begin
         busy_q    <= busy_d;
         deq_err_q <= deq_err_d;
         id_q      <= id_d;
         next_q    <= next_d;
      end
   end

endmodule
